// File: rtl/proc_controller_if.sv
// Control bus between the sequencer and the datapath / instruction ROM.
// The controller is the master; the datapath and ROM side is the slave.
interface proc_controller_if #(
    parameter int PC_WIDTH = 7
);
    logic [15:0]         IR_data;
    logic [PC_WIDTH-1:0] PC;
    logic [7:0]          D_addr;
    logic                D_wr;
    logic                RF_s;
    logic                RF_W_en;
    logic [3:0]          RF_W_addr;
    logic [3:0]          RF_Ra_addr;
    logic [3:0]          RF_Rb_addr;
    logic [2:0]          ALU_s;
    logic [3:0]          State;

    modport master (
        input  IR_data,
        output PC,
        output D_addr,
        output D_wr,
        output RF_s,
        output RF_W_en,
        output RF_W_addr,
        output RF_Ra_addr,
        output RF_Rb_addr,
        output ALU_s,
        output State
    );

    modport slave (
        output IR_data,
        input  PC,
        input  D_addr,
        input  D_wr,
        input  RF_s,
        input  RF_W_en,
        input  RF_W_addr,
        input  RF_Ra_addr,
        input  RF_Rb_addr,
        input  ALU_s,
        input  State
    );
endinterface

// File: rtl/proc_controller.sv
// Multi-cycle sequencer for the 16-bit datapath: holds PC, IR and the FSM,
// and decodes IR into register-file, data-memory and ALU control lines.
module proc_controller #(
    parameter int PC_WIDTH = 7
) (
    input  logic              Clock,
    input  logic              Resetn,
    proc_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_ALU = 4'd3,
        S_STORE    = 4'd4,
        S_LOAD_A   = 4'd5,
        S_LOAD_B   = 4'd6,
        S_HALT     = 4'd7
    } state_t;

    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_INC   = 4'h9;
    localparam logic [3:0] OP_MOV   = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_t              state;
    state_t              next;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;

    logic [3:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rq;
    logic [7:0] addr;
    logic [3:0] dop;

    assign op   = ir[15:12];
    assign ra   = ir[11:8];
    assign rb   = ir[7:4];
    assign rq   = ir[3:0];
    assign addr = ir[7:0];
    assign dop  = bus.IR_data[15:12];

    function automatic logic is_alu(input logic [3:0] o);
        return (o >= OP_ADD) && (o <= OP_MOV);
    endfunction

    function automatic logic [2:0] alu_sel(input logic [3:0] o);
        logic [2:0] s;
        s = 3'b000;
        case (o)
            OP_ADD:  s = 3'b000;
            OP_SUB:  s = 3'b001;
            OP_AND:  s = 3'b100;
            OP_OR:   s = 3'b101;
            OP_XOR:  s = 3'b110;
            OP_NOT:  s = 3'b111;
            OP_INC:  s = 3'b010;
            OP_MOV:  s = 3'b011;
            default: s = 3'b000;
        endcase
        return s;
    endfunction

    // IR and PC advance only on the edge leaving DECODE
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_INIT;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= next;
            if (state == S_DECODE) begin
                ir <= bus.IR_data;
                pc <= pc + PC_ONE;
            end
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            S_INIT:     next = S_FETCH;
            S_FETCH:    next = S_DECODE;
            S_DECODE: begin
                if (is_alu(dop))
                    next = S_EXEC_ALU;
                else if (dop == OP_STORE)
                    next = S_STORE;
                else if (dop == OP_LOAD)
                    next = S_LOAD_A;
                else if (dop == OP_HALT)
                    next = S_HALT;
                else
                    next = S_FETCH;
            end
            S_EXEC_ALU: next = S_FETCH;
            S_STORE:    next = S_FETCH;
            S_LOAD_A:   next = S_LOAD_B;
            S_LOAD_B:   next = S_FETCH;
            S_HALT:     next = S_HALT;
            default:    next = S_INIT;
        endcase
    end

    // Strobes derive from state only, so async reset kills them at once
    always_comb begin
        bus.D_addr     = 8'h00;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_en    = 1'b0;
        bus.RF_W_addr  = 4'h0;
        bus.RF_Ra_addr = 4'h0;
        bus.RF_Rb_addr = 4'h0;
        bus.ALU_s      = 3'b000;
        unique case (state)
            S_EXEC_ALU: begin
                bus.RF_Ra_addr = ra;
                bus.RF_Rb_addr = rb;
                bus.ALU_s      = alu_sel(op);
                bus.RF_W_addr  = rq;
                bus.RF_W_en    = 1'b1;
            end
            S_STORE: begin
                bus.RF_Ra_addr = ra;
                bus.D_addr     = addr;
                bus.D_wr       = 1'b1;
            end
            S_LOAD_A: begin
                bus.D_addr = addr;
            end
            S_LOAD_B: begin
                bus.D_addr    = addr;
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = ra;
                bus.RF_W_en   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.PC    = pc;
    assign bus.State = state;

endmodule

// File: tb/tb_proc_controller.sv
// Scoreboard bench for proc_controller: an instruction-level model predicts
// the per-cycle control trace; a negedge monitor compares the DUT against it.
module tb_proc_controller;

    typedef struct packed {
        logic [3:0] st;
        logic [6:0] pc;
        logic [7:0] da;
        logic       dw;
        logic       rs;
        logic       we;
        logic [3:0] wa;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } rec_t;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    string tname = "none";

    logic [15:0] rom [128];
    logic [2:0]  alu_tab [16];
    rec_t        exp_q [$];

    proc_controller_if #(.PC_WIDTH(7)) bus ();

    proc_controller #(.PC_WIDTH(7)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    // registered instruction ROM
    always @(posedge Clock) bus.IR_data <= rom[bus.PC];

    function automatic rec_t mk(input int st, input int pc);
        rec_t r;
        r = '0;
        r.st = 4'(st);
        r.pc = 7'(pc);
        return r;
    endfunction

    // instruction-level interpreter producing one record per clock cycle
    task automatic build(input int ncyc);
        int pc;
        int op;
        logic [15:0] w;
        rec_t r;
        pc = 0;
        exp_q.delete();
        exp_q.push_back(mk(0, 0));
        while (exp_q.size() < ncyc) begin
            w  = rom[pc];
            op = int'(w[15:12]);
            exp_q.push_back(mk(1, pc));
            exp_q.push_back(mk(2, pc));
            pc = (pc + 1) % 128;
            if (op == 15) begin
                while (exp_q.size() < ncyc) exp_q.push_back(mk(7, pc));
            end else if (op >= 3 && op <= 10) begin
                r = mk(3, pc);
                r.ra = w[11:8];
                r.rb = w[7:4];
                r.wa = w[3:0];
                r.we = 1'b1;
                r.alu = alu_tab[op];
                exp_q.push_back(r);
            end else if (op == 1) begin
                r = mk(4, pc);
                r.ra = w[11:8];
                r.da = w[7:0];
                r.dw = 1'b1;
                exp_q.push_back(r);
            end else if (op == 2) begin
                r = mk(5, pc);
                r.da = w[7:0];
                exp_q.push_back(r);
                r = mk(6, pc);
                r.da = w[7:0];
                r.rs = 1'b1;
                r.wa = w[11:8];
                r.we = 1'b1;
                exp_q.push_back(r);
            end
        end
        while (exp_q.size() > ncyc) void'(exp_q.pop_back());
    endtask

    always @(negedge Clock) begin
        rec_t e;
        rec_t g;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g.st = bus.State;
            g.pc = bus.PC;
            g.da = bus.D_addr;
            g.dw = bus.D_wr;
            g.rs = bus.RF_s;
            g.we = bus.RF_W_en;
            g.wa = bus.RF_W_addr;
            g.ra = bus.RF_Ra_addr;
            g.rb = bus.RF_Rb_addr;
            g.alu = bus.ALU_s;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: actual st=%0d pc=%0d da=%h dw=%b rs=%b we=%b wa=%h ra=%h rb=%h alu=%b required st=%0d pc=%0d da=%h dw=%b rs=%b we=%b wa=%h ra=%h rb=%h alu=%b",
                    tname, cyc, g.st, g.pc, g.da, g.dw, g.rs, g.we, g.wa, g.ra, g.rb, g.alu,
                    e.st, e.pc, e.da, e.dw, e.rs, e.we, e.wa, e.ra, e.rb, e.alu);
            end
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic run(input string name, input int ncyc);
        mon_en = 1'b0;
        Resetn = 1'b0;
        tname = name;
        cyc = 0;
        build(ncyc);
        @(posedge Clock);
        @(posedge Clock);
        #1 Resetn = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < ncyc + 10 && exp_q.size() != 0; i++) @(posedge Clock);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: actual %0d pending required 0", name, exp_q.size());
        end
        mon_en = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 16; i++) alu_tab[i] = 3'b000;
        alu_tab[3]  = 3'b000;
        alu_tab[4]  = 3'b001;
        alu_tab[5]  = 3'b100;
        alu_tab[6]  = 3'b101;
        alu_tab[7]  = 3'b110;
        alu_tab[8]  = 3'b111;
        alu_tab[9]  = 3'b010;
        alu_tab[10] = 3'b011;

        clear_rom();
        rom[1] = 16'hF000;
        run("noop_halt", 12);

        clear_rom();
        rom[0] = 16'h3123;
        rom[1] = 16'hF000;
        run("add", 10);

        clear_rom();
        for (int i = 0; i < 7; i++) rom[i] = {4'(i + 4), 12'h567};
        rom[7] = 16'hF000;
        run("alu_sweep", 28);

        clear_rom();
        rom[0] = 16'h2A1B;
        rom[1] = 16'h19C4;
        rom[2] = 16'hF000;
        run("load_store", 14);

        clear_rom();
        rom[5] = 16'hB321;
        rom[6] = 16'hE0FF;
        run("pc_wrap", 1 + 2 * 131);

        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 128; i++)
                rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
            rom[$urandom_range(40, 127)] = 16'hF000;
            run($sformatf("random%0d", s), 220);
        end

        // asynchronous reset in the middle of a STORE
        clear_rom();
        rom[0] = 16'h2A1B;
        rom[1] = 16'h19C4;
        rom[2] = 16'hF000;
        Resetn = 1'b0;
        @(posedge Clock);
        #1 Resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clock);
            if (bus.State == 4'd4) seen = 1'b1;
        end
        chk("store_reached", 32'(seen), 32'd1);
        chk("store_dwr", 32'(bus.D_wr), 32'd1);
        chk("store_pc", 32'(bus.PC), 32'd2);
        Resetn = 1'b0;
        #1;
        chk("arst_dwr", 32'(bus.D_wr), 32'd0);
        chk("arst_we", 32'(bus.RF_W_en), 32'd0);
        chk("arst_state", 32'(bus.State), 32'd0);
        chk("arst_pc", 32'(bus.PC), 32'd0);
        chk("arst_daddr", 32'(bus.D_addr), 32'd0);
        run("restart", 14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_controller.md
# proc_controller

Multi-cycle control unit for the 16-bit processor datapath. It fetches instructions from a registered instruction ROM, decodes them, and drives the register-file, data-memory and ALU control lines, including the 3-bit ALU function select. The datapath blocks consume its outputs; it holds the program counter, the instruction register and the sequencing FSM.

## Interface
- PC_WIDTH, 7: program counter / instruction ROM address width.
- Clock  in  1  single system clock; all state updates on the rising edge.
- Resetn  in  1  reset, asynchronous, active-low.
- IR_data  in  16  instruction ROM read data; ROM is registered, so data is valid one cycle after PC is presented.
- PC  out  PC_WIDTH  instruction ROM address.
- D_addr  out  8  data memory address.
- D_wr  out  1  data memory write strobe.
- RF_s  out  1  register-file write-data mux select: 0 = ALU result, 1 = data memory read data.
- RF_W_en  out  1  register-file write enable.
- RF_W_addr  out  4  register-file write address.
- RF_Ra_addr  out  4  read port A address (also the data memory write-data source).
- RF_Rb_addr  out  4  read port B address.
- ALU_s  out  3  ALU function select.
- State  out  4  current FSM state, for debug.

## Operation
- Instruction fields: op = IR[15:12], Ra = IR[11:8], Rb = IR[7:4], Rq = IR[3:0], addr = IR[7:0].
- Opcodes:
  - 0000 NOOP.
  - 0001 STORE: mem[addr] <= R[Ra].
  - 0010 LOAD: R[Ra] <= mem[addr].
  - 0011 ADD: ALU_s 000, R[Rq] <= R[Ra]+R[Rb].
  - 0100 SUB: 001.
  - 0101 AND: 100.
  - 0110 OR: 101.
  - 0111 XOR: 110.
  - 1000 NOT: 111.
  - 1001 INC: 010.
  - 1010 MOV: 011.
  - 1111 HALT.
  - Any other opcode is executed as NOOP.
- State encodings: INIT 0, FETCH 1, DECODE 2, EXEC_ALU 3, STORE 4, LOAD_A 5, LOAD_B 6, HALT 7.
- Transitions:
  - INIT goes to FETCH.
  - FETCH goes to DECODE.
  - DECODE dispatches on IR_data[15:12]:
    - ALU ops go to EXEC_ALU.
    - 0001 goes to STORE.
    - 0010 goes to LOAD_A.
    - 1111 goes to HALT.
    - All other opcodes go to FETCH.
  - EXEC_ALU and STORE go to FETCH.
  - LOAD_A goes to LOAD_B, which goes to FETCH.
  - HALT stays in HALT until reset.
- DECODE edge actions: IR <= IR_data; PC <= PC+1 (modulo 2^PC_WIDTH, so all-ones wraps to 0).
- PC and IR change only on that DECODE edge; they are frozen in every other state, including HALT.
- Outputs are combinational from State and IR. Default for every output not listed below is 0 (ALU_s 000, all addresses 0).
- Per-state outputs:
  - EXEC_ALU: RF_Ra_addr=Ra, RF_Rb_addr=Rb, ALU_s per opcode, RF_s=0, RF_W_addr=Rq, RF_W_en=1.
  - STORE: RF_Ra_addr=Ra, D_addr=addr, D_wr=1.
  - LOAD_A: D_addr=addr.
  - LOAD_B: D_addr=addr, RF_s=1, RF_W_addr=Ra, RF_W_en=1.
- Rb is driven for unary ops (NOT, INC, MOV) but is don't-care for them.

## Timing
- Reset values: State=INIT, PC=0, IR=0000h, and all outputs 0.
- Assertion of Resetn=0 mid-instruction forces INIT immediately (asynchronously). D_wr and RF_W_en drop in the same instant, so no partial write commits.
- The first FETCH follows one INIT cycle after Resetn deasserts.
- Instruction cycle counts:
  - NOOP and undefined opcodes: 2 cycles (FETCH, DECODE).
  - ALU ops and STORE: 3 cycles.
  - LOAD: 4 cycles.
- The register-file write and the memory write commit on the rising edge that ends EXEC_ALU, STORE or LOAD_B.
- A write in one instruction is visible to the next instruction's reads with no hazard, because sequencing is strictly serial.
- At most one of D_wr and RF_W_en is high in any cycle.

## Test plan
- Reset, then release with ROM[0]=0000h (NOOP), ROM[1]=F000h (HALT) → State sequence 0,1,2,1,2,7. PC=2 and stays at 2 in HALT; all strobes 0.
- ROM[0]=3123h (ADD) → in cycle 4 after reset release (EXEC_ALU): RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=3, ALU_s=000, RF_W_en=1, RF_s=0.
- Sweep opcodes 4..A with Ra=5, Rb=6, Rq=7 → ALU_s equals 001,100,101,110,111,010,011 respectively in EXEC_ALU.
- ROM[0]=2A1Bh (LOAD), ROM[1]=19C4h (STORE):
  - LOAD_A and LOAD_B: D_addr=1Bh.
  - LOAD_B: RF_s=1, RF_W_addr=Ah, RF_W_en=1.
  - Following STORE cycle: D_addr=C4h, RF_Ra_addr=9, D_wr=1.
- Pulse Resetn low during STORE → D_wr falls within the same cycle with no clock edge; State=0, PC=0; execution restarts from ROM[0].
- PC_WIDTH=2, ROM filled with NOOP → PC sequence 0,1,2,3,0 (wrap), with 2 cycles per instruction.
